// File: rtl/barcode_rdr.sv
// ============================================================================
//  Module      : barcode_rdr
//  Description : Self-timed serial barcode decoder producing an 8-bit station
//                ID with a valid flag acknowledged by the command processor.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module barcode_rdr #(
  parameter int TMR_W = 22
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       BC,
  input  logic       clr_ID_vld,
  output logic [7:0] ID,
  output logic       ID_vld
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    WAIT_FALL = 3'd2,
    SAMPLE    = 3'd3,
    DONE      = 3'd4
  } state_t;

  localparam logic [TMR_W-1:0] C_TMR_MAX = '1;

  state_t           r_state;
  state_t           w_state_n;
  logic             r_bc_meta;
  logic             r_bc_sync;
  logic             r_bc_prev;
  logic [TMR_W-1:0] r_tmr;
  logic [TMR_W-1:0] w_tmr_n;
  logic [TMR_W-1:0] w_tmr_inc;
  logic [TMR_W-1:0] r_period;
  logic [TMR_W-1:0] w_period_n;
  logic [2:0]       r_bit_cnt;
  logic [2:0]       w_bit_cnt_n;
  logic [7:0]       r_shft;
  logic [7:0]       w_shft_n;
  logic [7:0]       r_id;
  logic [7:0]       w_id_n;
  logic             r_id_vld;
  logic             w_id_vld_n;
  logic             w_fall;
  logic             w_rise;
  logic             w_tmr_sat;

  // Sync chain resets high so an idle line never looks like a falling edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bc_meta <= 1'b1;
      r_bc_sync <= 1'b1;
      r_bc_prev <= 1'b1;
    end else begin
      r_bc_meta <= BC;
      r_bc_sync <= r_bc_meta;
      r_bc_prev <= r_bc_sync;
    end
  end

  assign w_fall    = r_bc_prev & ~r_bc_sync;
  assign w_rise    = ~r_bc_prev & r_bc_sync;
  assign w_tmr_sat = (r_tmr == C_TMR_MAX);
  assign w_tmr_inc = w_tmr_sat ? r_tmr : r_tmr + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_tmr     <= '0;
      r_period  <= '0;
      r_bit_cnt <= 3'd0;
      r_shft    <= 8'h00;
      r_id      <= 8'h00;
      r_id_vld  <= 1'b0;
    end else begin
      r_state   <= w_state_n;
      r_tmr     <= w_tmr_n;
      r_period  <= w_period_n;
      r_bit_cnt <= w_bit_cnt_n;
      r_shft    <= w_shft_n;
      r_id      <= w_id_n;
      r_id_vld  <= w_id_vld_n;
    end
  end

  always_comb begin
    w_state_n   = r_state;
    w_tmr_n     = r_tmr;
    w_period_n  = r_period;
    w_bit_cnt_n = r_bit_cnt;
    w_shft_n    = r_shft;
    w_id_n      = r_id;
    // An acceptance in DONE below overrides this clear.
    w_id_vld_n  = clr_ID_vld ? 1'b0 : r_id_vld;

    case (r_state)
      IDLE: begin
        if (w_fall) begin
          w_tmr_n   = '0;
          w_state_n = START;
        end
      end

      START: begin
        if (w_rise) begin
          w_period_n  = r_tmr;
          w_bit_cnt_n = 3'd0;
          w_tmr_n     = w_tmr_inc;
          w_state_n   = WAIT_FALL;
        end else if (w_tmr_sat) begin
          w_state_n = IDLE;
        end else begin
          w_tmr_n = w_tmr_inc;
        end
      end

      WAIT_FALL: begin
        if (w_fall) begin
          w_tmr_n   = '0;
          w_state_n = SAMPLE;
        end else if (w_tmr_sat) begin
          w_state_n = IDLE;
        end else begin
          w_tmr_n = w_tmr_inc;
        end
      end

      SAMPLE: begin
        w_tmr_n = w_tmr_inc;
        if (r_tmr == r_period) begin
          w_shft_n    = {r_shft[6:0], r_bc_sync};
          w_bit_cnt_n = r_bit_cnt + 3'd1;
          w_state_n   = (r_bit_cnt == 3'd7) ? DONE : WAIT_FALL;
        end
      end

      DONE: begin
        if (r_shft[7:6] == 2'b00) begin
          w_id_n     = r_shft;
          w_id_vld_n = 1'b1;
        end
        w_state_n = IDLE;
      end

      default: w_state_n = IDLE;
    endcase
  end

  assign ID     = r_id;
  assign ID_vld = r_id_vld;

endmodule

`default_nettype wire

// File: tb/tb_barcode_rdr.sv
// ============================================================================
//  Module      : tb_barcode_rdr
//  Description : Self-checking bench for barcode_rdr (vector table, scoreboard
//                of accepted IDs, hand sequences for reset/timeout/ack cases).
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_barcode_rdr;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       bc, clr, bc8, clr8;
  logic [7:0] id, id8;
  logic       vld, vld8;

  always #5 clk = ~clk;

  barcode_rdr #(.TMR_W(22)) dut (
    .clk(clk), .rst_n(rst_n), .BC(bc), .clr_ID_vld(clr), .ID(id), .ID_vld(vld)
  );

  barcode_rdr #(.TMR_W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .BC(bc8), .clr_ID_vld(clr8), .ID(id8), .ID_vld(vld8)
  );

  int         n_tests = 0;
  int         n_fail  = 0;
  int         n_push  = 0;
  int         n_pop   = 0;
  logic [7:0] sb_q[$];
  logic       wave[$];
  int         falls[9];

  typedef struct {
    logic [7:0] data;
    int         p;
    bit         clr_before;
    logic [7:0] exp_id;
    logic       exp_vld;
    bit         chk_lat;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic pulse_clr();
    @(posedge clk); #1;
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
  endtask

  // Per-cycle line levels: start low p / high p/2, then 8 bits MSB first, idle tail.
  task automatic build(input logic [7:0] data, input int p);
    int lo, hi;
    wave.delete();
    falls[0] = 0;
    for (int i = 0; i < p; i++) wave.push_back(1'b0);
    for (int i = 0; i < p / 2; i++) wave.push_back(1'b1);
    for (int b = 0; b < 8; b++) begin
      falls[b+1] = wave.size();
      lo = data[7-b] ? p / 2 : 3 * p / 2;
      hi = data[7-b] ? 3 * p / 2 : p / 2;
      for (int i = 0; i < lo; i++) wave.push_back(1'b0);
      for (int i = 0; i < hi; i++) wave.push_back(1'b1);
    end
    for (int i = 0; i < 10; i++) wave.push_back(1'b1);
  endtask

  // Last-bit fall driven after edge k: DONE occupies the cycle after edge k+p+3,
  // and ID/ID_vld change at edge k+p+4 (2 sync + 1 edge flop + p + DONE).
  task automatic play(input bit sel, input logic [7:0] data, input int p,
                      input bit clr_done, input bit chk_lat,
                      input int cut_bit, input bit cut_rst);
    int k, cut_idx;
    build(data, p);
    k       = falls[8];
    cut_idx = (cut_bit >= 0) ? falls[cut_bit] : -1;
    if (cut_bit < 0 && data[7:6] == 2'b00 && !sel) begin
      sb_q.push_back(data);
      n_push++;
    end
    for (int j = 0; j < wave.size(); j++) begin
      @(posedge clk); #1;
      if (chk_lat && j == k + p + 3) check("lat_before", sel ? vld8 : vld, 1'b0);
      if (chk_lat && j == k + p + 4) begin
        check("lat_vld", sel ? vld8 : vld, 1'b1);
        check("lat_id", sel ? id8 : id, data);
      end
      if (j == cut_idx) begin
        if (cut_rst) rst_n = 1'b0;
        break;
      end
      if (sel) begin
        bc8  = wave[j];
        clr8 = clr_done && (j == k + p + 3);
      end else begin
        bc  = wave[j];
        clr = clr_done && (j == k + p + 3);
      end
    end
    clr  = 1'b0;
    clr8 = 1'b0;
  endtask

  // Scoreboard monitor: an acceptance is ID_vld rising or ID changing while valid.
  logic       prev_vld = 1'b0;
  logic [7:0] prev_id  = 8'h00;
  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      prev_vld = 1'b0;
    end else begin
      if (vld && (!prev_vld || id != prev_id)) begin
        if (sb_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL sb_unexpected: got ID %0h, none expected", id);
        end else begin
          n_pop++;
          check("sb_id", id, sb_q.pop_front());
        end
      end
      prev_vld = vld;
      prev_id  = id;
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{8'h35, 100, 1'b0, 8'h35, 1'b1, 1'b1};
    vecs[1] = '{8'hB5, 100, 1'b1, 8'h35, 1'b0, 1'b0};
    vecs[2] = '{8'h00, 100, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[3] = '{8'h3F,  60, 1'b1, 8'h3F, 1'b1, 1'b1};
    vecs[4] = '{8'hC0, 100, 1'b1, 8'h3F, 1'b0, 1'b0};
    vecs[5] = '{8'h15, 100, 1'b0, 8'h15, 1'b1, 1'b1};
    vecs[6] = '{8'h7F, 100, 1'b0, 8'h15, 1'b1, 1'b0};

    rst_n = 1'b0;
    bc    = 1'b1;
    clr   = 1'b0;
    bc8   = 1'b1;
    clr8  = 1'b0;
    idle(3);
    check("rst_id", id, 8'h00);
    check("rst_vld", vld, 1'b0);
    check("rst_id8", id8, 8'h00);
    check("rst_vld8", vld8, 1'b0);
    rst_n = 1'b1;
    idle(5);

    for (int i = 0; i < 7; i++) begin
      if (vecs[i].clr_before) pulse_clr();
      play(1'b0, vecs[i].data, vecs[i].p, 1'b0, vecs[i].chk_lat, -1, 1'b0);
      check($sformatf("vec%0d_id", i), id, vecs[i].exp_id);
      check($sformatf("vec%0d_vld", i), vld, vecs[i].exp_vld);
    end

    // Acknowledge handling
    check("ack_pre_vld", vld, 1'b1);
    pulse_clr();
    check("ack_clears", vld, 1'b0);
    pulse_clr();
    check("ack_when_idle", vld, 1'b0);
    play(1'b0, 8'h12, 100, 1'b1, 1'b1, -1, 1'b0);
    check("ack_vs_set_id", id, 8'h12);
    check("ack_vs_set_vld", vld, 1'b1);

    // Reset mid-frame after the 3rd data bit
    play(1'b0, 8'h2A, 100, 1'b0, 1'b0, 4, 1'b1);
    #1;
    check("midrst_id", id, 8'h00);
    check("midrst_vld", vld, 1'b0);
    idle(3);
    rst_n = 1'b1;
    idle(10);
    play(1'b0, 8'h0A, 100, 1'b0, 1'b1, -1, 1'b0);
    check("postrst_id", id, 8'h0A);
    check("postrst_vld", vld, 1'b1);

    // Long period, then overwrite while valid
    play(1'b0, 8'h3F, 1000, 1'b0, 1'b0, -1, 1'b0);
    check("longp_id", id, 8'h3F);
    check("longp_vld", vld, 1'b1);
    play(1'b0, 8'h01, 100, 1'b0, 1'b0, -1, 1'b0);
    check("ovwr_id", id, 8'h01);
    check("ovwr_vld", vld, 1'b1);

    // Narrow timer: stuck-low line, short frame, then a good frame
    bc8 = 1'b0;
    idle(300);
    bc8 = 1'b1;
    idle(20);
    check("stuck_vld8", vld8, 1'b0);
    check("stuck_id8", id8, 8'h00);
    play(1'b1, 8'h55, 40, 1'b0, 1'b0, 4, 1'b0);
    idle(300);
    check("short_vld8", vld8, 1'b0);
    check("short_id8", id8, 8'h00);
    play(1'b1, 8'h11, 40, 1'b0, 1'b1, -1, 1'b0);
    check("tmr8_id8", id8, 8'h11);
    check("tmr8_vld8", vld8, 1'b1);

    idle(5);
    check("sb_empty", sb_q.size(), 0);
    check("sb_pops", n_pop, n_push);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
